fc_layer: RTL and testbench

- Fully-connected (dense) stage directly downstream of the CONV engine.
- Consumes the 2048-entry Layer-2 flatten output through the same layer-memory read port style as CONV: crd / csel / caddr_rd / cdata_rd, with csel = 3'b101.
- Reads weights from an external weight ROM and produces NUM_OUT neuron scores in signed 4.16 fixed point, one per output beat.

---
 rtl/fc_layer.sv | 160 ++++++++++++++++
 tb/tb_fc_layer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer.sv
// Dense layer: dot products of the L2 flatten vector with ROM weights, one signed 4.16 score per neuron (FC_RELU_EN clamps negatives to 0).
// Latency: NUM_IN+3 cycles per neuron, one FIN cycle at the end; the address stream streams one entry per cycle.
// Backpressure: none; memories answer one cycle after each read, and start is ignored while a pass is running.
module fc_layer #(
    parameter int NUM_IN  = 2048,
    parameter int NUM_OUT = 4,
    parameter int ACC_W   = 52,
    parameter int WADDR_W = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               crd,
    output logic [2:0]         csel,
    output logic [11:0]        caddr_rd,
    input  logic [19:0]        cdata_rd,
    output logic               wrd,
    output logic [WADDR_W-1:0] waddr,
    input  logic [19:0]        wdata,
    output logic               out_valid,
    output logic [1:0]         out_idx,
    output logic [19:0]        out_data
);

    localparam int KW = $clog2(NUM_IN);
    localparam int JW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, FIN} state_t;

    state_t                   state;
    logic [JW-1:0]            j;
    logic [KW-1:0]            k;
    logic                     drain_cnt;
    logic                     rd_vld;
    logic                     prod_vld;
    logic signed [39:0]       prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  shr;
    logic [ACC_W-20:0]        hi;
    logic [19:0]              res;

    // Final sum is folded in the same cycle it lands, so OUT can present it immediately.
    always_comb begin
        acc_nxt = prod_vld ? acc + {{(ACC_W-40){prod[39]}}, prod} : acc;
        rnd     = acc_nxt + (ACC_W'(1) << 15);
        shr     = rnd >>> 16;
        hi      = shr[ACC_W-1:19];
        res     = shr[19:0];
        if (!((&hi) || (~|hi)))
            res = shr[ACC_W-1] ? 20'h80000 : 20'h7FFFF;
`ifdef FC_RELU_EN
        if (res[19])
            res = 20'h00000;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld   <= 1'b0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
        end else begin
            rd_vld   <= crd;
            prod_vld <= rd_vld;
            if (rd_vld)
                prod <= $signed(cdata_rd) * $signed(wdata);
            if (state == FETCH && k == '0)
                acc <= '0;
            else
                acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            j         <= '0;
            k         <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crd       <= 1'b0;
            csel      <= 3'b000;
            caddr_rd  <= '0;
            wrd       <= 1'b0;
            waddr     <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= FETCH;
                        j        <= '0;
                        k        <= '0;
                        busy     <= 1'b1;
                        crd      <= 1'b1;
                        wrd      <= 1'b1;
                        csel     <= 3'b101;
                        caddr_rd <= '0;
                        waddr    <= '0;
                    end
                end
                FETCH: begin
                    if (k == KW'(NUM_IN - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                        crd       <= 1'b0;
                        wrd       <= 1'b0;
                        csel      <= 3'b000;
                    end else begin
                        k        <= k + 1'b1;
                        caddr_rd <= 12'(k + 1'b1);
                        waddr    <= waddr + 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_idx   <= 2'(j);
                        out_data  <= res;
                    end
                end
                OUT: begin
                    out_valid <= 1'b0;
                    if (j == JW'(NUM_OUT - 1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Weight address simply continues: row j+1 starts right after row j.
                        state    <= FETCH;
                        j        <= j + 1'b1;
                        k        <= '0;
                        crd      <= 1'b1;
                        wrd      <= 1'b1;
                        csel     <= 3'b101;
                        caddr_rd <= '0;
                        waddr    <= waddr + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: memory models, a dot-product reference model and a per-cycle compare process.
module tb_fc_layer;

    localparam int NI  = 2048;
    localparam int NO  = 4;
    localparam int PER = NI + 3;
    localparam int TOT = NO * PER;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [2:0]  csel;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic        wrd;
    logic [12:0] waddr;
    logic [19:0] wdata;
    logic        out_valid;
    logic [1:0]  out_idx;
    logic [19:0] out_data;

    fc_layer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .crd(crd), .csel(csel), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .wrd(wrd), .waddr(waddr), .wdata(wdata),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    logic [19:0] lmem [NI];
    logic [19:0] wmem [NI*NO];
    logic [19:0] exp_out [NO];
    logic [19:0] hold_dat;
    logic [1:0]  hold_idx;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          track = 0;
    bit          pass_done = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, want);
        end
    endtask

    // Memories: address seen in cycle t, data presented from cycle t+1.
    always @(posedge clk) begin
        logic        c_en, w_en;
        logic [11:0] ca;
        logic [12:0] wa;
        c_en = crd; w_en = wrd; ca = caddr_rd; wa = waddr;
        #1;
        if (c_en) cdata_rd = lmem[ca[10:0]];
        if (w_en) wdata = wmem[wa];
    end

    function automatic logic [19:0] relu_of(input logic [19:0] v);
`ifdef FC_RELU_EN
        return v[19] ? 20'h00000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [19:0] model(input int jn);
        longint acc;
        longint r;
        acc = 0;
        for (int kk = 0; kk < NI; kk++)
            acc += longint'($signed(lmem[kk])) * longint'($signed(wmem[jn*NI+kk]));
        r = (acc + 32768) >>> 16;
        if (r > 524287) r = 524287;
        if (r < -524288) r = -524288;
        return relu_of(r[19:0]);
    endfunction

    // Expected timeline of a pass, indexed from the first FETCH cycle.
    always @(negedge clk) begin
        int  n, p;
        bit  fe, ov;
        if (track) begin
            n  = cyc / PER;
            p  = cyc % PER;
            fe = (cyc < TOT) && (p < NI);
            ov = (cyc < TOT) && (p == NI + 2);
            chk("busy", busy, (cyc < TOT));
            chk("done", done, (cyc == TOT));
            chk("crd", crd, fe);
            chk("wrd", wrd, fe);
            chk("csel", csel, fe ? 3'b101 : 3'b000);
            if (fe) begin
                chk("caddr_rd", caddr_rd, p);
                chk("waddr", waddr, n * NI + p);
            end
            chk("out_valid", out_valid, ov);
            if (ov) begin
                hold_dat = exp_out[n];
                hold_idx = 2'(n);
            end
            chk("out_idx", out_idx, hold_idx);
            chk("out_data", out_data, hold_dat);
            if (cyc == TOT) begin
                track = 0;
                pass_done = 1;
            end
            cyc++;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_crd"}, crd, 0);
        chk({tag, "_csel"}, csel, 0);
        chk({tag, "_caddr"}, caddr_rd, 0);
        chk({tag, "_wrd"}, wrd, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    // restart_at: loop cycle for an extra start pulse while busy; abort_at: cycle to hit reset (-1 = none).
    task automatic run_pass(input int restart_at, input int abort_at);
        for (int jn = 0; jn < NO; jn++) exp_out[jn] = model(jn);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        cyc = 0; pass_done = 0; track = 1;
        for (int i = 0; i < TOT + 20 && !pass_done; i++) begin
            @(posedge clk); #1;
            start = (i == restart_at) || (i == TOT - 1);
            if (i == abort_at) begin
                track = 0;
                reset = 1;
                start = 1;
                @(posedge clk); #1;
                chk_zero("abort");
                reset = 0;
                start = 0;
                hold_dat = 0;
                hold_idx = 0;
                @(posedge clk); #1;
                chk("start_under_reset_busy", busy, 0);
                return;
            end
        end
        start = 0;
        chk("pass_completed", pass_done, 1);
        repeat (2) @(negedge clk);
        chk("idle_after_fin_start", busy, 0);
    endtask

    task automatic fill_random();
        int v;
        for (int kk = 0; kk < NI; kk++) begin
            v = int'($urandom_range(0, 32766)) - 16383;
            lmem[kk] = v[19:0];
        end
        for (int a = 0; a < NI*NO; a++) begin
            v = int'($urandom_range(0, 2046)) - 1023;
            wmem[a] = v[19:0];
        end
    endtask

    initial begin
        reset = 1; start = 0; cdata_rd = 0; wdata = 0;
        hold_dat = 0; hold_idx = 0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        reset = 0;

        // Unity average, with a redundant start mid-run.
        for (int kk = 0; kk < NI; kk++) lmem[kk] = 20'h10000;
        for (int a = 0; a < NI*NO; a++) wmem[a] = 20'h00010;
        for (int jn = 0; jn < NO; jn++) chk("pin_unity", model(jn), 20'h08000);
        run_pass(500, -1);

        // Mixed sign and saturation per neuron.
        for (int jn = 0; jn < NO; jn++)
            for (int kk = 0; kk < NI; kk++)
                wmem[jn*NI+kk] = (jn == 0) ? 20'h00010 : (jn == 1) ? 20'hFFFF0 :
                                 (jn == 2) ? 20'h10000 : 20'hF0000;
        chk("pin_neg", model(1), relu_of(20'hF8000));
        chk("pin_sat_pos", model(2), 20'h7FFFF);
        chk("pin_sat_neg", model(3), relu_of(20'h80000));
        run_pass(3000, -1);

        // Most-negative input against extreme weights.
        for (int kk = 0; kk < NI; kk++) lmem[kk] = 20'h80000;
        for (int jn = 0; jn < NO; jn++)
            for (int kk = 0; kk < NI; kk++)
                wmem[jn*NI+kk] = (jn == 0) ? 20'h7FFFF : (jn == 1) ? 20'h80000 :
                                 (jn == 2) ? 20'h00000 : 20'h00001;
        chk("pin_sat_min", model(0), relu_of(20'h80000));
        chk("pin_sat_max", model(1), 20'h7FFFF);
        chk("pin_small_neg", model(3), relu_of(20'hFC000));
        run_pass(-1, -1);

        // Rounding at the half-LSB boundary.
        for (int kk = 0; kk < NI; kk++) lmem[kk] = 20'h0;
        for (int a = 0; a < NI*NO; a++) wmem[a] = 20'h0;
        lmem[0] = 20'h00001;
        wmem[0] = 20'h08000; wmem[NI] = 20'h07FFF; wmem[2*NI] = 20'h18000; wmem[3*NI] = 20'hF8000;
        chk("pin_round_up", model(0), 20'h00001);
        chk("pin_round_down", model(1), 20'h00000);
        chk("pin_round_two", model(2), 20'h00002);
        chk("pin_round_negzero", model(3), 20'h00000);
        run_pass(-1, -1);

        // Random pass cut by reset during neuron 2, then a fresh random pass.
        fill_random();
        run_pass(-1, 2*PER + 300);
        fill_random();
        run_pass(1000, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
